// File: rtl/readout_scheduler_pkg.sv
// readout_pkg: shared types and constants for the readout scheduler slice.
//   state_t      - scheduler phases (IDLE, SETTLE, DWELL, RELEASE)
//   DEF_*        - default parameter values for the top level
//   idx_width()  - bits needed to index N channels (at least 1)
//   cnt_width()  - bits needed for a counter that must reach max_val
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    DWELL   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_INPUT_BITS     = 8;
  localparam int DEF_SETTLE_CYCLES  = 100;
  localparam int DEF_DWELL_EDGES    = 10;
  localparam int DEF_TIMEOUT_CYCLES = 1048575;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/readout_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req     - request vector, one bit per channel
//   ptr     - index of the most recently served channel
//   gnt     - one-hot winner (all zero when nothing requests)
//   idx     - binary index of the winner (0 when nothing requests)
//   any_req - at least one request bit is set
// The search starts just above ptr and wraps, so the last winner has the
// lowest priority on the next round.
module rr_arbiter
  import readout_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int IDX_W = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any_req
);

  int   cand;
  logic found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = (int'(ptr) + off) % NUM_CH;
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = IDX_W'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_scheduler.sv
// readout_scheduler: time-shares one light-to-frequency converter between
// NUM_CH pixel channels. A channel is granted round-robin, its level is
// loaded into the converter, the converter is given SETTLE_CYCLES to settle
// and then DWELL_EDGES rising edges of its output are counted.
//   CLK, RST_N  - clock, asynchronous active-low reset
//   REQ         - per-channel request, held until DONE/TIMEOUT
//   LEVEL       - flattened channel levels, channel c at [c*INPUT_BITS +: INPUT_BITS]
//   FREQ_IN     - converter output, synchronous to CLK
//   FM_INPUT    - level driven to the converter (held between grants)
//   GNT, CH_IDX - one-hot grant and index of the granted/last-granted channel
//   BUSY        - high in SETTLE, DWELL and RELEASE
//   DONE        - one-cycle pulse on the completed channel's bit
//   TIMEOUT     - one-cycle pulse when DWELL runs out of time
//   PERIOD_OUT  - cycles from first to last counted edge of the last DONE
// Optional feature macro: READOUT_PERIOD_MEAS_EN enables PERIOD_OUT;
// without it PERIOD_OUT is tied to 0.
module readout_scheduler
  import readout_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int INPUT_BITS     = DEF_INPUT_BITS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int DWELL_EDGES    = DEF_DWELL_EDGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDX_W = idx_width(NUM_CH)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NUM_CH-1:0]            REQ,
  input  logic [NUM_CH*INPUT_BITS-1:0] LEVEL,
  input  logic                         FREQ_IN,
  output logic [INPUT_BITS-1:0]        FM_INPUT,
  output logic [NUM_CH-1:0]            GNT,
  output logic [IDX_W-1:0]             CH_IDX,
  output logic                         BUSY,
  output logic [NUM_CH-1:0]            DONE,
  output logic                         TIMEOUT,
  output logic [31:0]                  PERIOD_OUT
);

  localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
  localparam int EDGE_W   = cnt_width(DWELL_EDGES);
  localparam int TO_W     = cnt_width(TIMEOUT_CYCLES);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [NUM_CH-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]        ch_q, ch_d;
  logic [INPUT_BITS-1:0]   fm_q, fm_d;
  logic                    busy_q, busy_d;
  logic [NUM_CH-1:0]       done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic [SETTLE_W-1:0]     settle_q, settle_d;
  logic [EDGE_W-1:0]       edge_q, edge_d, edge_inc;
  logic [TO_W-1:0]         to_q, to_d, to_inc;
  logic                    freq_q;
  logic                    rise;
  logic [NUM_CH-1:0]       arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (REQ),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  assign rise     = FREQ_IN & ~freq_q;
  assign edge_inc = edge_q + EDGE_W'(1);
  assign to_inc   = to_q + TO_W'(1);

  // Next-state and next-output logic. Every output is computed here and
  // registered below. Losing the request aborts the readout ahead of
  // completion or timeout; completion beats timeout in the same cycle.
  // GNT drops on entry to RELEASE so the converter is visibly free there.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    ch_d      = ch_q;
    fm_d      = fm_q;
    busy_d    = busy_q;
    done_d    = '0;
    timeout_d = 1'b0;
    settle_d  = settle_q;
    edge_d    = edge_q;
    to_d      = to_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d  = SETTLE;
          gnt_d    = arb_gnt;
          ch_d     = arb_idx;
          fm_d     = LEVEL[int'(arb_idx)*INPUT_BITS +: INPUT_BITS];
          busy_d   = 1'b1;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (!REQ[ch_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_d = DWELL;
          edge_d  = '0;
          to_d    = '0;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      DWELL: begin
        if (!REQ[ch_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else begin
          to_d = to_inc;
          if (rise) edge_d = edge_inc;
          if (rise && edge_inc == EDGE_W'(DWELL_EDGES)) begin
            done_d  = gnt_q;
            state_d = RELEASE;
            gnt_d   = '0;
          end else if (to_inc == TO_W'(TIMEOUT_CYCLES)) begin
            timeout_d = 1'b1;
            state_d   = RELEASE;
            gnt_d     = '0;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = ch_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; freq_q tracks FREQ_IN in every state so the
  // first DWELL cycle already has a valid edge reference.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NUM_CH - 1);
      gnt_q     <= '0;
      ch_q      <= '0;
      fm_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      settle_q  <= '0;
      edge_q    <= '0;
      to_q      <= '0;
      freq_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      ch_q      <= ch_d;
      fm_q      <= fm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      settle_q  <= settle_d;
      edge_q    <= edge_d;
      to_q      <= to_d;
      freq_q    <= FREQ_IN;
    end
  end

`ifdef READOUT_PERIOD_MEAS_EN
  logic [31:0] per_cnt_q;
  logic [31:0] period_q;

  // The span counter runs only once the first edge of this dwell has been
  // seen (edge_q != 0) and saturates. At DONE the completing cycle itself is
  // added, so the result is the distance between first and last edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      per_cnt_q <= '0;
      period_q  <= '0;
    end else begin
      if (state_q != DWELL) begin
        per_cnt_q <= '0;
      end else if (edge_q != '0 && per_cnt_q != '1) begin
        per_cnt_q <= per_cnt_q + 32'd1;
      end
      if (|done_d) begin
        if (edge_q == '0) begin
          period_q <= '0;
        end else if (per_cnt_q == '1) begin
          period_q <= '1;
        end else begin
          period_q <= per_cnt_q + 32'd1;
        end
      end
    end
  end

  assign PERIOD_OUT = period_q;
`else
  assign PERIOD_OUT = '0;
`endif

  assign FM_INPUT = fm_q;
  assign GNT      = gnt_q;
  assign CH_IDX   = ch_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: doc/readout_scheduler.md
Name: readout_scheduler

Overview:
- Time-shares one light-to-frequency converter (8-bit level in, square wave out) between NUM_CH pixel channels.
- Grants channels round-robin and loads the granted channel's level into the converter input.
- Waits a settle time, then counts DWELL_EDGES rising edges of the converter output. Signals completion per channel, or a timeout if the output is too slow or stuck.
- Sits between the pixel front-ends and the single frequency converter instance in the readout path.

Parameters:
NUM_CH, 4, number of requesting channels (2..16)
INPUT_BITS, 8, converter level width
SETTLE_CYCLES, 100, CLK cycles after a level load before edge counting starts (>=1)
DWELL_EDGES, 10, FREQ_IN rising edges counted per readout (>=1)
TIMEOUT_CYCLES, 1048575, max CLK cycles in DWELL before abort (>=DWELL_EDGES*2)

Ports:
CLK  input  1  single clock, rising edge
RST_N  input  1  asynchronous, active-low reset
REQ  input  NUM_CH  per-channel readout request, level-held until DONE/TIMEOUT
LEVEL  input  NUM_CH*INPUT_BITS  flattened levels, channel c at [c*INPUT_BITS +: INPUT_BITS]
FREQ_IN  input  1  converter output fed back, CLK-synchronous
FM_INPUT  output  INPUT_BITS  level driven to converter
GNT  output  NUM_CH  one-hot grant, all-zero when idle
CH_IDX  output  clog2(NUM_CH)  index of granted/last-granted channel
BUSY  output  1  high in SETTLE, DWELL, RELEASE
DONE  output  NUM_CH  one-cycle pulse on the completed channel's bit
TIMEOUT  output  1  one-cycle pulse on timeout abort
PERIOD_OUT  output  32  see Optional Feature

Behaviour:
- Reset (async assert, sync release): state IDLE; FM_INPUT=0, GNT=0, CH_IDX=0, BUSY=0, DONE=0, TIMEOUT=0, PERIOD_OUT=0; rr pointer=NUM_CH-1; counters 0; freq_q=0.
- Edge detect: freq_q<=FREQ_IN every cycle in all states; rise = FREQ_IN & ~freq_q.
- IDLE:
  - If any REQ bit is set at edge k, pick the first set bit searching upward from (ptr+1) mod NUM_CH, wrapping.
  - At edge k, register GNT=onehot(w), CH_IDX=w, FM_INPUT=LEVEL[w] and go to SETTLE. GNT is therefore visible one cycle after REQ is seen.
  - FM_INPUT is sampled only at grant; later LEVEL changes are ignored.
- SETTLE: count SETTLE_CYCLES cycles, then go to DWELL with edge count=0 and timeout count=0. Edges during SETTLE are ignored.
- DWELL:
  - Each rise increments the edge count.
  - On reaching DWELL_EDGES: pulse DONE[w] for 1 cycle and go to RELEASE.
  - Timeout count increments every cycle. When it reaches TIMEOUT_CYCLES without completion: pulse TIMEOUT and go to RELEASE, with no DONE.
  - If edge completion and timeout occur in the same cycle, DONE wins.
- RELEASE: GNT=0, ptr=w, go to IDLE. This gives one idle cycle between grants. FM_INPUT holds its last value, so the converter sees no glitch to 0.
- Abort: if REQ[w] drops during SETTLE or DWELL, go to RELEASE next cycle with no DONE and no TIMEOUT. REQ changes on other channels never affect the current grant.
- Fairness: a channel that holds REQ waits at most NUM_CH-1 other readouts.
- Async reset mid-readout returns to the reset values immediately; no DONE is issued.
- Counter widths are clog2(param+1). All outputs are registered.

Optional Feature:
- Macro: READOUT_PERIOD_MEAS_EN.
- When defined:
  - A 32-bit cycle counter starts at the first rise in DWELL and stops at the DWELL_EDGES-th rise.
  - PERIOD_OUT is loaded with the count in the same cycle DONE pulses and holds until the next DONE.
  - If DWELL_EDGES=1, the count is 0.
  - The counter saturates at 2^32-1.
- When undefined: PERIOD_OUT is tied to 0 and no counter logic exists.

Decomposition:
- Package readout_pkg: state enum (IDLE, SETTLE, DWELL, RELEASE), default parameter constants, and a clog2-based width function.
- Sub-module rr_arbiter: combinational round-robin pick. Inputs are req vector and pointer; outputs are one-hot winner, index and any_req. It is reusable for future multi-converter variants.

Test Plan:
All scenarios use NUM_CH=4, SETTLE_CYCLES=4, DWELL_EDGES=3, TIMEOUT_CYCLES=200, with FREQ_IN driven by the bench at period 10 cycles.
- Reset: RST_N low with REQ=4'b1111 -> all outputs 0. Release -> GNT=4'b0001 and FM_INPUT=LEVEL[0] one cycle after the first IDLE sample.
- Single readout: REQ=4'b0100, LEVEL[2]=8'hA5 -> FM_INPUT=8'hA5 and CH_IDX=2. DONE=4'b0100 pulses on the 3rd FREQ_IN rise after SETTLE, then GNT=0.
- Round-robin: REQ=4'b1111 held -> grant order 0,1,2,3,0, each separated by a RELEASE cycle with GNT=0.
- Timeout: FREQ_IN stuck low, REQ=4'b0001 -> TIMEOUT pulses exactly 200 cycles after DWELL entry, no DONE, then the next grant proceeds.
- Abort: drop REQ[1] mid-DWELL -> GNT=0 next cycle, no DONE or TIMEOUT, and FM_INPUT keeps its value. Assert RST_N low mid-SETTLE -> immediate reset values.
- With READOUT_PERIOD_MEAS_EN: FREQ_IN period 10 cycles, DWELL_EDGES=3 -> PERIOD_OUT=20 at DONE.
